instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Consumer end of the program-counter address stream.
- Takes the 15-bit instruction address from the program counter and fetches the 16-bit Hack instruction from an external instruction memory. That memory may have variable latency and a request/grant/response handshake.
- Presents the instruction to the CPU decode stage and raises stall so the PC holds until the instruction is delivered.
- Discards in-flight fetches on flush (jump taken); detects a non-responding memory with a timeout.

Parameters:
- ADDR_W, 15, instruction address width (matches PC width).
- DATA_W, 16, instruction width.
- TIMEOUT, 255, maximum cycles in WAIT before abort; range 1..65535; counter width = clog2(TIMEOUT+1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- fetch_en  input  1  CPU requests the instruction at pc.
- pc  input  ADDR_W  address to fetch; sampled only when leaving IDLE.
- flush  input  1  jump taken; abandon the current fetch.
- instr  output  DATA_W  last delivered instruction; held between deliveries.
- instr_valid  output  1  one-cycle pulse: instr is new this cycle.
- stall  output  1  PC must not advance.
- fetch_err  output  1  sticky timeout flag; cleared only by reset.
- mem_req  output  1  memory request, registered.
- mem_addr  output  ADDR_W  request address, registered; stable while mem_req=1.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  DATA_W  read data.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; mem_req=0, mem_addr=0, instr=0, instr_valid=0, fetch_err=0, timeout counter=0. Reset asserted mid-fetch abandons the fetch immediately; a late mem_rvalid after reset release is ignored in IDLE.
- States: IDLE, REQ, WAIT, DROP.
- IDLE:
  - If fetch_en=1 and flush=0: mem_addr<=pc, mem_req<=1, go to REQ.
  - flush in IDLE has no effect beyond suppressing the launch that cycle.
- REQ:
  - mem_req stays 1 and mem_addr stays constant until mem_gnt=1.
  - On mem_gnt: mem_req<=0, counter<=0, go to WAIT.
  - flush=1 with mem_gnt=0: mem_req<=0, go to IDLE.
  - flush=1 with mem_gnt=1: mem_req<=0, go to DROP.
- WAIT:
  - On mem_rvalid=1 and flush=0: instr<=mem_rdata, instr_valid<=1 for exactly one cycle, go to IDLE.
  - flush=1 with mem_rvalid=0: go to DROP.
  - flush=1 with mem_rvalid=1: data discarded (no instr_valid), go to IDLE.
  - Counter increments each WAIT cycle. When counter reaches TIMEOUT without mem_rvalid: fetch_err<=1, instr unchanged, no instr_valid, go to IDLE.
- DROP:
  - Wait for mem_rvalid. Data is discarded and instr is unchanged; go to IDLE on the rvalid.
  - The same TIMEOUT rule applies.
  - flush while in DROP is ignored.
- Exactly one memory transaction is outstanding at any time. A new request is never issued before the previous response or timeout.
- stall = (state!=IDLE) | (fetch_en & state==IDLE & !flush); combinational. During the instr_valid pulse cycle the state is IDLE, so stall follows fetch_en for the next fetch.
- Latency:
  - Zero-wait memory (gnt in the REQ cycle, rvalid the next cycle): instr_valid asserts 3 cycles after fetch_en is seen in IDLE.
  - Back-to-back fetches: 3 cycles per instruction.
- Address wrap: pc=15'h7FFF is fetched normally; the block does no address arithmetic.
- mem_rvalid in IDLE or REQ (spurious) is ignored.
- fetch_err does not block further fetches.

Test Plan:
- Basic fetch: reset, pc=15'h0010, fetch_en=1; memory grants at once and returns 16'hEC10 the next cycle -> mem_req high 1 cycle with mem_addr=15'h0010; instr=16'hEC10 with instr_valid one-cycle pulse; stall low in the pulse cycle only if fetch_en=0.
- Grant backpressure: hold mem_gnt=0 for 4 cycles -> mem_req and mem_addr remain stable for 5 cycles; stall=1 throughout; data 16'h0007 is delivered after the grant.
- Flush in WAIT: flush 2 cycles after grant, then memory returns 16'hFFFF -> no instr_valid; instr keeps its old value; next fetch pc=15'h0020 returns 16'h1234 correctly.
- Simultaneous flush+gnt and flush+rvalid -> first case goes to DROP and discards the later data; second case discards the data and returns to IDLE; no instr_valid in either case.
- Timeout with TIMEOUT=8: grant then never send rvalid -> fetch_err=1 after 8 WAIT cycles; state returns to IDLE; a subsequent normal fetch succeeds and fetch_err stays 1.
- Async reset mid-WAIT: assert reset between clock edges -> all outputs 0 immediately; a later stray mem_rvalid with 16'hABCD produces no instr_valid.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches Hack instructions for the PC over a
// request/grant/response memory port and stalls the PC until delivery.
// Ports: clk, reset (async, active-high);
//   CPU side:    fetch_en, pc, flush -> instr, instr_valid, stall, fetch_err
//   memory side: mem_req, mem_addr -> ; <- mem_gnt, mem_rvalid, mem_rdata
module instr_fetch_unit #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              stall,
    output logic              fetch_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_n;
    logic [CW-1:0]     cnt_inc;
    logic              timeout;
    logic              req_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] instr_n;
    logic              valid_n;
    logic              err_n;

    // cnt counts response-wait cycles since the grant; the abort fires
    // on the edge where the count would reach TIMEOUT.
    assign cnt_inc = cnt + CW'(1);
    assign timeout = (cnt_inc == CW'(TIMEOUT));

    assign stall = (state != IDLE) | (fetch_en & (state == IDLE) & ~flush);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mem_req     <= req_n;
            mem_addr    <= addr_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
            fetch_err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        req_n   = mem_req;
        addr_n  = mem_addr;
        instr_n = instr;
        valid_n = 1'b0;
        err_n   = fetch_err;
        unique case (state)
            IDLE: begin
                if (fetch_en && !flush) begin
                    addr_n  = pc;
                    req_n   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    // A granted request always owes a response, so a
                    // flush here must still drain it in DROP.
                    req_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = flush ? DROP : WAIT;
                end else if (flush) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_n = IDLE;
                    if (!flush) begin
                        instr_n = mem_rdata;
                        valid_n = 1'b1;
                    end
                end else if (timeout) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    // Count keeps running into DROP: the limit bounds the
                    // whole time the transaction is outstanding.
                    cnt_n = cnt_inc;
                    if (flush) begin
                        state_n = DROP;
                    end
                end
            end
            DROP: begin
                if (mem_rvalid) begin
                    state_n = IDLE;
                end else if (timeout) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
